imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Write side of the instruction memory: takes a byte stream from the host/assembler link,
//  packs it big-endian into 32-bit MIPS words and writes them at word addresses 0,1,2,...
//  The instruction memory reads these addresses as memory[PC].
//  Holds the core (cpu_hold) for the whole load so fetch never sees a half-written program.
// PARAMETERS
//  DEPTH   32  words of instruction memory; legal write addresses 0..DEPTH-1
//  ADDR_W  5   width of the internal word counter, clog2(DEPTH)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   reset, asynchronous, active-low
//  start        in   1   1-cycle pulse: begin new load at word 0
//  byte_valid   in   1   host has byte_data
//  byte_data    in   8   stream byte; first byte of each word = bits [31:24]
//  byte_last    in   1   qualifies final byte of program (valid with byte_valid)
//  byte_ready   out  1   loader accepts byte this cycle
//  mem_we       out  1   write strobe to instruction memory, 1 cycle per word
//  mem_addr     out  32  word index (same indexing as PC into memory[]), upper bits 0
//  mem_wdata    out  32  word to write
//  cpu_hold     out  1   1 while loading; core held in reset
//  load_done    out  1   1-cycle pulse, load finished OK
//  load_err     out  1   sticky overflow flag, cleared by start or reset
//  words_loaded out  ADDR_W+1  count of words written this load
// BEHAVIOUR
//  Reset values (async on rst_n low, any state): state=IDLE, all outputs 0, byte counter 0,
//   word counter 0, pack register 0. The reset is asynchronous; release is sampled on clk.
//  Handshake: byte is taken on a clk edge with byte_valid & byte_ready.
//   byte_ready = 1 only in LOAD, combinational from state. Host may hold byte_valid when ready=0.
//  States:
//   IDLE: cpu_hold=0. Go to LOAD on start.
//   LOAD: cpu_hold=1, byte_ready=1. Shift the byte into the pack register; byte_cnt counts 0..3.
//   DONE: one cycle. load_done=1 and cpu_hold=1. Next state is IDLE.
//   ERR: byte_ready=0, cpu_hold=1, load_err=1. Leave only on start (to LOAD) or reset.
//  Packing: byte k of a word (k=0..3) goes to bits [31-8k -: 8].
//  Write timing: mem_we, mem_addr and mem_wdata are registered.
//   mem_we is high exactly 1 cycle, in the cycle after the 4th byte of a word is accepted.
//   mem_addr = the word counter before increment. The counter increments with the write.
//   words_loaded updates in the same cycle as mem_we.
//   LOAD keeps byte_ready=1 during the write cycle, so there are no bubbles. Throughput is 1 byte/clk.
//  byte_last on a byte that completes a word: write that word as normal, then go to DONE.
//  byte_last on a partial word (1-3 bytes): pad the unfilled low bytes with 0x00.
//   Write the padded word next cycle, then go to DONE.
//  byte_last on a word boundary with no pending bytes cannot occur: the last byte always fills
//   some byte slot.
//  Overflow: a byte that would start word DEPTH (counter==DEPTH, byte_cnt==0) is not written.
//   Go to ERR; load_err=1 from the next cycle. Words 0..DEPTH-1 stay intact.
//  Exactly DEPTH full words, with last on the final byte: legal, DONE, no error.
//  start while in LOAD or DONE: restart at word 0. Discard partial bytes, clear the counters
//   and load_err. Any write already registered still completes.
//  start and an accepted byte in the same cycle: start wins and the byte is dropped.
//  rst_n low mid-load: abort at once. cpu_hold=0 and mem_we=0 asynchronously.
//   Memory contents are undefined; software must reload.
//  Combinational paths: only byte_ready, which depends on state alone. No input-to-output paths.
// TESTING
//  1. Reset, start, bytes 20 08 00 05 with last on 0x05
//     -> mem_we 1 cycle after 0x05, addr 0, data 0x20080005, load_done next cycle, words_loaded=1.
//  2. 12 bytes back-to-back with byte_valid held high
//     -> writes at addr 0,1,2 each 4 clk apart, byte_ready never drops, cpu_hold 1 from start to done.
//  3. 6 bytes AA BB CC DD 11 22 with last on 0x22
//     -> writes 0xAABBCCDD at addr 0, then 0x11220000 at addr 1, load_done, words_loaded=2.
//  4. DEPTH=32: 33 words -> addr 0..31 written.
//     On the 1st byte of word 32: no write, load_err=1, byte_ready=0.
//     start -> err clears, addr restarts at 0.
//  5. rst_n low after 2 bytes of word 1 -> outputs 0 at once.
//     After release, in IDLE; a fresh load writes addr 0.
//  6. start pulsed while LOAD holds 3 pending bytes
//     -> partial discarded, no write, next 4 bytes land at addr 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus for imem_loader.
// The master side is the host stream and the memory; the slave side is the loader.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output byte_valid, byte_data, byte_last,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data, byte_last,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words
// written at word addresses 0,1,2,... while holding the core.
module imem_loader #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    // FIN is the write cycle of the final word; DONE follows it.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_FIN  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]       state, state_d;
    logic [1:0]       byte_cnt, byte_cnt_d;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      pack, pack_d, pack_new;
    logic             we_d;
    logic [31:0]      addr_d, wdata_d;
    logic             hold_d, done_d, err_d;

    assign bus.byte_ready = (state == S_LOAD);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state;
        byte_cnt_d = byte_cnt;
        cnt_d      = words_loaded;
        pack_d     = pack;
        we_d       = 1'b0;
        addr_d     = bus.mem_addr;
        wdata_d    = bus.mem_wdata;
        pack_new   = (byte_cnt == 2'd0) ? 32'h0 : pack;

        case (byte_cnt)
            2'd0:    pack_new[31:24] = bus.byte_data;
            2'd1:    pack_new[23:16] = bus.byte_data;
            2'd2:    pack_new[15:8]  = bus.byte_data;
            default: pack_new[7:0]   = bus.byte_data;
        endcase

        if (start) begin
            // Restart wins over any byte offered in the same cycle.
            state_d    = S_LOAD;
            byte_cnt_d = 2'd0;
            cnt_d      = '0;
            pack_d     = 32'h0;
        end else begin
            case (state)
                S_IDLE: state_d = S_IDLE;
                S_LOAD: begin
                    if (bus.byte_valid) begin
                        if (byte_cnt == 2'd0 && words_loaded == CNT_W'(DEPTH)) begin
                            state_d = S_ERR;
                        end else begin
                            pack_d     = pack_new;
                            byte_cnt_d = 2'(byte_cnt + 2'd1);
                            // Partial last word is already zero-padded in pack_new.
                            if (byte_cnt == 2'd3 || bus.byte_last) begin
                                we_d       = 1'b1;
                                addr_d     = 32'(words_loaded);
                                wdata_d    = pack_new;
                                cnt_d      = CNT_W'(words_loaded + 1'b1);
                                byte_cnt_d = 2'd0;
                                if (bus.byte_last) state_d = S_FIN;
                            end
                        end
                    end
                end
                S_FIN:   state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end

        hold_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            byte_cnt      <= 2'd0;
            words_loaded  <= '0;
            pack          <= 32'h0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            cpu_hold      <= 1'b0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            state         <= state_d;
            byte_cnt      <= byte_cnt_d;
            words_loaded  <= cnt_d;
            pack          <= pack_d;
            bus.mem_we    <= we_d;
            bus.mem_addr  <= addr_d;
            bus.mem_wdata <= wdata_d;
            cpu_hold      <= hold_d;
            load_done     <= done_d;
            load_err      <= err_d;
        end
    end
endmodule
